alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter FUNCT_W, default 4, funct field width (>=4).
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control width (>=4); control codes zero-extended.
REQ-003 SHALL have parameter MUL_CYC, default 4, mul execute cycles (>=1).
REQ-004 SHALL have parameter DIV_CYC, default 16, div execute cycles (>=1).
REQ-005 SHALL have parameter CNT_W, default 5, cycle counter width, holding max(MUL_CYC,DIV_CYC)-1.
REQ-006 SHALL have ports, in this order:
 clk  in  1  clock, rising edge
 rst  in  1  reset, asynchronous, active-low
 flush  in  1  synchronous abort of the op in flight
 in_valid  in  1  request present
 in_ready  out  1  block can accept a request
 alu_op  in  2  {ALUOp1,ALUOp0}
 funct  in  FUNCT_W  function field
 alu_ctrl  out  CTRL_W  control code to ALU
 ctrl_valid  out  1  alu_ctrl meaningful this cycle
 alu_busy  out  1  multi-cycle op executing
 op_done  out  1  one-cycle pulse, op's last execute cycle
 illegal  out  1  one-cycle pulse, rejected request

Function
REQ-007 SHALL implement FSM states IDLE and EXEC only.
REQ-008 in_ready SHALL equal 1 in IDLE when flush=0, else 0; a request is accepted on an edge where in_valid & in_ready.
REQ-009 Decode SHALL be: alu_op 10 -> 0011 (lw/sw); 01 -> 0100 (branch); 00 -> funct passed through if in {1111,1110,1101,1100,0001,0010,1010,1011,1000,1001}; anything else illegal.
REQ-010 With FUNCT_W>4, funct SHALL be legal only if bits above [3:0] are zero.
REQ-011 Execute length SHALL be MUL_CYC for 0001, DIV_CYC for 0010, 1 otherwise.
REQ-012 Legal accept at edge N: FSM enters EXEC, alu_ctrl registered with code, counter loaded with length-1, ctrl_valid=1 from cycle N+1.
REQ-013 In EXEC counter SHALL decrement per cycle; when counter==0, op_done=1 and FSM returns to IDLE at next edge; single-cycle op: op_done in cycle N+1, in_ready=1 in cycle N+2.
REQ-014 alu_busy SHALL be 1 in EXEC for multi-cycle ops (length>1), 0 otherwise; alu_ctrl held stable throughout EXEC.
REQ-015 Illegal accept SHALL produce illegal=1 in cycle N+1, alu_ctrl=0, ctrl_valid=0, op_done=0, FSM stays IDLE.
REQ-016 flush=1 in EXEC SHALL return FSM to IDLE at next edge, clear ctrl_valid/alu_busy, suppress op_done that cycle; flush with in_valid in IDLE SHALL block acceptance.
REQ-017 In IDLE ctrl_valid, alu_busy, op_done SHALL be 0; alu_ctrl retains last code.

Reset
REQ-018 rst=0 SHALL asynchronously force IDLE, counter=0, alu_ctrl=0, ctrl_valid=0, alu_busy=0, op_done=0, illegal=0; in_ready=0 while rst=0.
REQ-019 Reset mid-EXEC SHALL abort the op with no op_done; first accept possible on first edge after rst deasserts.

Structure
REQ-020 Package alu_ctrl_pkg SHALL hold ALUOp encodings, the ten ALU control codes, FSM state type.
REQ-021 Combinational decode (legal check, code, length) SHALL be sub-module alu_funct_decode; alu_ctrl_seq holds FSM and counter.

Verification
REQ-022 Reset: rst=0 mid-div, release -> all outputs 0, in_ready=1 next cycle.
REQ-023 alu_op=00 funct=1111 accepted -> alu_ctrl=1111, ctrl_valid=1 and op_done=1 one cycle later, alu_busy=0.
REQ-024 alu_op=00 funct=0010, DIV_CYC=16 -> alu_busy=1 for 16 cycles, op_done in 16th, in_ready=0 throughout.
REQ-025 alu_op=11, and alu_op=00 funct=0111 -> illegal pulse, ctrl_valid=0, no op_done.
REQ-026 Mul accepted, flush at 2nd EXEC cycle -> IDLE next edge, no op_done; back-to-back add requests with in_valid held -> one accept per 2 cycles.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp values, ALU control codes, FSM state.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_R   = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_MEM = 2'b10;

  localparam logic [3:0] CTRL_MUL  = 4'b0001;
  localparam logic [3:0] CTRL_DIV  = 4'b0010;
  localparam logic [3:0] CTRL_LWSW = 4'b0011;
  localparam logic [3:0] CTRL_BR   = 4'b0100;
  localparam logic [3:0] CTRL_C8   = 4'b1000;
  localparam logic [3:0] CTRL_C9   = 4'b1001;
  localparam logic [3:0] CTRL_CA   = 4'b1010;
  localparam logic [3:0] CTRL_CB   = 4'b1011;
  localparam logic [3:0] CTRL_CC   = 4'b1100;
  localparam logic [3:0] CTRL_CD   = 4'b1101;
  localparam logic [3:0] CTRL_CE   = 4'b1110;
  localparam logic [3:0] CTRL_CF   = 4'b1111;

  typedef enum logic {IDLE, EXEC} state_t;

  // R-type funct values that pass straight through as control codes
  function automatic logic is_r_code(input logic [3:0] f);
    case (f)
      CTRL_MUL, CTRL_DIV, CTRL_C8, CTRL_C9, CTRL_CA, CTRL_CB,
      CTRL_CC, CTRL_CD, CTRL_CE, CTRL_CF: is_r_code = 1'b1;
      default:                            is_r_code = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational decode of {alu_op, funct}: legality, control code and execute length.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4,
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 16,
  parameter int CNT_W   = 5
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               legal,
  output logic [CTRL_W-1:0]  code,
  output logic [CNT_W-1:0]   len_m1,
  output logic               multi
);

  logic [3:0] code4;
  logic       hi_zero;

  // wide funct fields are only legal when everything above the low nibble is zero
  assign hi_zero = ((funct >> 4) == '0);
  assign code    = CTRL_W'(code4);

  always_comb begin
    legal  = 1'b0;
    code4  = 4'b0000;
    len_m1 = '0;
    multi  = 1'b0;
    case (alu_op)
      ALUOP_MEM: begin
        legal = 1'b1;
        code4 = CTRL_LWSW;
      end
      ALUOP_BR: begin
        legal = 1'b1;
        code4 = CTRL_BR;
      end
      ALUOP_R: begin
        if (hi_zero && is_r_code(funct[3:0])) begin
          legal = 1'b1;
          code4 = funct[3:0];
          if (funct[3:0] == CTRL_MUL) begin
            len_m1 = CNT_W'(MUL_CYC - 1);
            multi  = (MUL_CYC > 1);
          end else if (funct[3:0] == CTRL_DIV) begin
            len_m1 = CNT_W'(DIV_CYC - 1);
            multi  = (DIV_CYC > 1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: accepts decode requests, holds the control code for the op's
// execute length and signals completion, rejection or flush.
//   state | meaning
//   IDLE  | waiting for a request; in_ready high unless flushing
//   EXEC  | control code valid, counter running down to the last execute cycle
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4,
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               ctrl_valid,
  output logic               alu_busy,
  output logic               op_done,
  output logic               illegal
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               done_q;
  logic               dec_legal;
  logic [CTRL_W-1:0]  dec_code;
  logic [CNT_W-1:0]   dec_len_m1;
  logic               dec_multi;

  alu_funct_decode #(
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W),
    .MUL_CYC (MUL_CYC),
    .DIV_CYC (DIV_CYC),
    .CNT_W   (CNT_W)
  ) u_dec (
    .alu_op (alu_op),
    .funct  (funct),
    .legal  (dec_legal),
    .code   (dec_code),
    .len_m1 (dec_len_m1),
    .multi  (dec_multi)
  );

  assign in_ready = rst && (state == IDLE) && !flush;
  // a flush landing on the last execute cycle kills the completion pulse immediately
  assign op_done  = done_q && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_ctrl   <= '0;
      ctrl_valid <= 1'b0;
      alu_busy   <= 1'b0;
      done_q     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          ctrl_valid <= 1'b0;
          alu_busy   <= 1'b0;
          done_q     <= 1'b0;
          if (in_valid && !flush) begin
            if (dec_legal) begin
              state      <= EXEC;
              alu_ctrl   <= dec_code;
              cnt        <= dec_len_m1;
              ctrl_valid <= 1'b1;
              alu_busy   <= dec_multi;
              done_q     <= (dec_len_m1 == '0);
            end else begin
              illegal  <= 1'b1;
              alu_ctrl <= '0;
            end
          end
        end
        EXEC: begin
          if (flush || cnt == '0) begin
            state      <= IDLE;
            cnt        <= '0;
            ctrl_valid <= 1'b0;
            alu_busy   <= 1'b0;
            done_q     <= 1'b0;
          end else begin
            cnt    <= cnt - 1'b1;
            done_q <= (cnt == CNT_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq with default parameters (MUL_CYC=4, DIV_CYC=16).
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [3:0] funct;
  logic [3:0] alu_ctrl;
  logic       ctrl_valid;
  logic       alu_busy;
  logic       op_done;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         ill;
    logic [3:0] code;
    int         len;
  } exp_t;

  exp_t sb[$];

  alu_ctrl_seq dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_ctrl   (alu_ctrl),
    .ctrl_valid (ctrl_valid),
    .alu_busy   (alu_busy),
    .op_done    (op_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn);
    exp_t e;
    e.ill = 1'b0; e.code = 4'b0000; e.len = 1;
    if (op == 2'b10) e.code = 4'b0011;
    else if (op == 2'b01) e.code = 4'b0100;
    else if (op == 2'b00 && (fn == 4'hF || fn == 4'hE || fn == 4'hD || fn == 4'hC ||
             fn == 4'h1 || fn == 4'h2 || fn == 4'hA || fn == 4'hB || fn == 4'h8 || fn == 4'h9)) begin
      e.code = fn;
      if (fn == 4'h1) e.len = 4;
      if (fn == 4'h2) e.len = 16;
    end else e.ill = 1'b1;
    return e;
  endfunction

  // scoreboard: every completion or rejection pulse must match the oldest expected request
  always @(negedge clk) begin
    if (rst === 1'b1 && (op_done === 1'b1 || illegal === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: op_done=%0b illegal=%0b with nothing expected", op_done, illegal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (illegal !== e.ill || op_done !== !e.ill || alu_ctrl !== e.code || ctrl_valid !== !e.ill) begin
          errors++;
          $display("FAIL sb_result: got ill=%0b done=%0b ctrl=%b cv=%0b, want ill=%0b done=%0b ctrl=%b cv=%0b",
                   illegal, op_done, alu_ctrl, ctrl_valid, e.ill, !e.ill, e.code, !e.ill);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
  endtask

  // called at a negedge with in_ready high; returns 1ns after the accepting edge
  task automatic drive_req(input logic [1:0] op, input logic [3:0] fn, input bit track);
    if (track) sb.push_back(model(op, fn));
    alu_op = op; funct = fn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle();
    drive_req(2'b00, 4'h2, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (alu_busy !== 1'b1 || ctrl_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: busy=%b cv=%b, want 1 1", alu_busy, ctrl_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({alu_ctrl, ctrl_valid, alu_busy, op_done, illegal, in_ready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_async: ctrl=%b cv=%b busy=%b done=%b ill=%b rdy=%b, want all 0",
               alu_ctrl, ctrl_valid, alu_busy, op_done, illegal, in_ready);
    end
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || {alu_ctrl, ctrl_valid, alu_busy, op_done, illegal} !== 8'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b ctrl=%b cv=%b busy=%b done=%b, want 1 and 0s",
               in_ready, alu_ctrl, ctrl_valid, alu_busy, op_done);
    end
  endtask

  task automatic test_single();
    logic [1:0] ops[5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [3:0] fns[5] = '{4'hF, 4'h7, 4'h5, 4'h8, 4'hC};
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e = model(ops[i], fns[i]);
      wait_idle();
      drive_req(ops[i], fns[i], 1'b1);
      @(negedge clk);
      checks++;
      if (alu_ctrl !== e.code || ctrl_valid !== 1'b1 || op_done !== 1'b1 || alu_busy !== 1'b0) begin
        errors++;
        $display("FAIL single_%0d: ctrl=%b cv=%b done=%b busy=%b, want %b 1 1 0",
                 i, alu_ctrl, ctrl_valid, op_done, alu_busy, e.code);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || ctrl_valid !== 1'b0 || alu_ctrl !== e.code) begin
        errors++;
        $display("FAIL single_idle_%0d: rdy=%b cv=%b ctrl=%b, want 1 0 %b",
                 i, in_ready, ctrl_valid, alu_ctrl, e.code);
      end
    end
  endtask

  task automatic test_multi(input logic [3:0] fn);
    exp_t e;
    int bad = 0;
    e = model(2'b00, fn);
    wait_idle();
    drive_req(2'b00, fn, 1'b1);
    for (int c = 1; c <= e.len; c++) begin
      @(negedge clk);
      if (alu_busy !== 1'b1 || in_ready !== 1'b0 || op_done !== (c == e.len) || alu_ctrl !== fn) begin
        bad++;
        $display("FAIL multi_%b_cyc%0d: busy=%b rdy=%b done=%b ctrl=%b, want 1 0 %0b %b",
                 fn, c, alu_busy, in_ready, op_done, alu_ctrl, (c == e.len), fn);
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(negedge clk);
    checks++;
    if (alu_busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_%b_end: busy=%b rdy=%b, want 0 1", fn, alu_busy, in_ready);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ops[3] = '{2'b11, 2'b00, 2'b00};
    logic [3:0] fns[3] = '{4'hF, 4'h7, 4'h0};
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      drive_req(ops[i], fns[i], 1'b1);
      @(negedge clk);
      checks++;
      if (illegal !== 1'b1 || ctrl_valid !== 1'b0 || op_done !== 1'b0 || alu_ctrl !== 4'b0) begin
        errors++;
        $display("FAIL illegal_%0d: ill=%b cv=%b done=%b ctrl=%b, want 1 0 0 0000",
                 i, illegal, ctrl_valid, op_done, alu_ctrl);
      end
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_pulse_%0d: ill=%b rdy=%b, want 0 1", i, illegal, in_ready);
      end
    end
  endtask

  task automatic test_flush();
    wait_idle();
    drive_req(2'b00, 4'h1, 1'b0);
    @(negedge clk);
    checks++;
    if (alu_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_mul_busy: busy=%b, want 1", alu_busy);
    end
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    checks++;
    if (op_done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_mul_cyc2: done=%b rdy=%b, want 0 0", op_done, in_ready);
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_valid !== 1'b0 || alu_busy !== 1'b0 || in_ready !== 1'b1 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_mul_idle: cv=%b busy=%b rdy=%b done=%b, want 0 0 1 0",
               ctrl_valid, alu_busy, in_ready, op_done);
    end
    // flush on the only execute cycle of a single-cycle op
    drive_req(2'b00, 4'hA, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (op_done !== 1'b0 || ctrl_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_last: done=%b cv=%b, want 0 1", op_done, ctrl_valid);
    end
    // flush held with a request in IDLE must block acceptance
    in_valid = 1'b1; alu_op = 2'b10;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || ctrl_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_block: rdy=%b cv=%b, want 0 0", in_ready, ctrl_valid);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    wait_idle();
    for (int k = 0; k < 4; k++) sb.push_back(model(2'b00, 4'hE));
    alu_op = 2'b00; funct = 4'hE; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ctrl_valid !== (i % 2 == 0) || in_ready !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL b2b_cyc%0d: cv=%b rdy=%b, want %0b %0b", i, ctrl_valid, in_ready,
                 (i % 2 == 0), (i % 2 == 1));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) errors++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi(4'h2);
    test_multi(4'h1);
    test_illegal();
    test_flush();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected results never produced, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
